// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_stream_reader
//  Purpose  : Pops a synchronous FIFO (one-cycle read latency) into a 2-entry
//             buffer and presents it as a framed valid/ready stream.
//             Define READER_STATS_EN to add the stall_cnt output.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_LEN  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  fifo_empty,
    output logic                  fifo_rd,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  frame_cnt,
    output logic                  busy
`ifdef READER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  stall_cnt
`endif
);

    localparam int c_IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_STOP   = 2'd2
    } state_t;

    state_t                r_state;
    logic [1:0]            r_occ;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;
    logic [c_IDX_W-1:0]    r_idx;
    logic [CNT_WIDTH-1:0]  r_frame_cnt;

    logic                  w_pop;
    logic                  w_head_last;
    logic [1:0]            w_level;

    assign w_pop       = (r_occ != 2'd0) && m_ready;
    assign w_head_last = (r_idx == c_LAST_IDX);
    // occ + inflight never exceeds 2, so the 2-bit sum cannot wrap
    assign w_level     = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};

    assign fifo_rd   = !rst && enable && !flush && !fifo_empty && (w_level < 2'd2);
    assign m_valid   = (r_occ != 2'd0);
    assign m_data    = r_buf0;
    assign m_last    = m_valid && w_head_last;
    assign frame_cnt = r_frame_cnt;
    assign busy      = (r_occ != 2'd0) || r_inflight || (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_occ       <= 2'd0;
            r_inflight  <= 1'b0;
            r_buf0      <= '0;
            r_buf1      <= '0;
            r_idx       <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_inflight <= fifo_rd;
            if (w_pop) begin
                r_idx <= w_head_last ? '0 : r_idx + c_IDX_W'(1);
                if (w_head_last) begin
                    r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
                end
            end
            if (flush) begin
                // a word arriving this cycle is simply not captured
                r_occ   <= 2'd0;
                r_idx   <= '0;
                r_state <= enable ? S_ACTIVE : S_IDLE;
            end else begin
                r_occ <= w_level;
                case ({r_inflight, w_pop})
                    2'b10: begin
                        if (r_occ == 2'd0) r_buf0 <= fifo_data;
                        else               r_buf1 <= fifo_data;
                    end
                    2'b01: r_buf0 <= r_buf1;
                    2'b11: begin
                        if (r_occ == 2'd2) begin
                            r_buf0 <= r_buf1;
                            r_buf1 <= fifo_data;
                        end else begin
                            r_buf0 <= fifo_data;
                        end
                    end
                    default: ;
                endcase
                case (r_state)
                    S_IDLE:   if (enable) r_state <= S_ACTIVE;
                    S_ACTIVE: if (!enable) r_state <= S_STOP;
                    S_STOP: begin
                        if (enable)                                r_state <= S_ACTIVE;
                        else if ((r_occ == 2'd0) && !r_inflight)   r_state <= S_IDLE;
                    end
                    default:  r_state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef READER_STATS_EN
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (m_ready && !m_valid && (r_state == S_ACTIVE) && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
